// File: rtl/wb_port_arbiter_pkg.sv
// wb_port_arbiter_pkg: shared arbiter state encoding and default widths.
package wb_port_arbiter_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, FORCE = 2'd2} state_e;
    localparam int DEF_DEPTH    = 4;
    localparam int DEF_MAX_WAIT = 8;
    localparam int DEF_AW       = 6;
    localparam int DEF_DW       = 32;
endpackage

// File: rtl/wb_port_arbiter_result_fifo.sv
// wb_result_fifo: long-result queue exposing per-entry valid/address for hazard lookup.
module wb_result_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 38,
    parameter int AW    = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [W-1:0]             data_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [W-1:0]             head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [DEPTH-1:0]         valid_o,
    output logic [AW-1:0]            addr_o [DEPTH]
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] rd_q, wr_q;
    logic [CW-1:0] cnt_q;
    assign full_o  = cnt_q == CW'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;
    always_ff @(posedge clk)
        if (push_i) mem_q[wr_q] <= data_i;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_q + PW'(pop_i);
            wr_q  <= wr_q + PW'(push_i);
            cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
        end
    end
    // An entry is live when its distance from the read pointer is below the count.
    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        assign valid_o[i] = {1'b0, PW'(i) - rd_q} < cnt_q;
        assign addr_o[i]  = mem_q[i][W-1 -: AW];
    end
endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between WB and the long unit,
// with a starvation counter forcing one queued long write after MAX_WAIT denials.
module wb_port_arbiter import wb_port_arbiter_pkg::*; #(
    parameter int DEPTH    = DEF_DEPTH,
    parameter int MAX_WAIT = DEF_MAX_WAIT,
    parameter int AW       = DEF_AW,
    parameter int DW       = DEF_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          PipeWE,
    input  logic [AW-1:0] PipeWAddr,
    input  logic [DW-1:0] PipeWData,
    output logic          PipeStall,
    input  logic          LongValid,
    input  logic [AW-1:0] LongWAddr,
    input  logic [DW-1:0] LongWData,
    output logic          LongReady,
    output logic          RegWE,
    output logic [AW-1:0] RegWAddr,
    output logic [DW-1:0] RegWData,
    input  logic [AW-1:0] QueryAddr,
    output logic          QueryHit
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int WW = $clog2(MAX_WAIT + 1);
    logic                 full, empty, push, pop, deny, force_d, we_d;
    logic [AW+DW-1:0]     head, grant_d;
    logic [CW-1:0]        cnt;
    logic [DEPTH-1:0]     ent_valid;
    logic [AW-1:0]        ent_addr [DEPTH];
    logic [WW-1:0]        wait_q, wait_d;
    state_e               state_q, state_d;
    wb_result_fifo #(.DEPTH(DEPTH), .W(AW + DW), .AW(AW)) u_fifo (
        .clk(clk), .rst_n(reset), .push_i(push), .pop_i(pop),
        .data_i({LongWAddr, LongWData}), .full_o(full), .empty_o(empty),
        .head_o(head), .count_o(cnt), .valid_o(ent_valid), .addr_o(ent_addr)
    );
    assign LongReady = reset && !full;
    assign push      = LongValid && LongReady;
    assign PipeStall = state_q == FORCE;
    always_comb begin
        pop     = !empty && (PipeStall || !PipeWE);
        deny    = !empty && !pop;
        we_d    = pop || PipeWE;
        grant_d = pop ? head : {PipeWAddr, PipeWData};
        force_d = deny && wait_q == WW'(MAX_WAIT - 1);
        wait_d  = (deny && !force_d) ? wait_q + WW'(1) : '0;
        state_d = force_d ? FORCE : ((cnt + CW'(push)) != CW'(pop) ? WAIT : IDLE);
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            wait_q   <= '0;
            RegWE    <= 1'b0;
            RegWAddr <= '0;
            RegWData <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            RegWE   <= we_d;
            if (we_d) {RegWAddr, RegWData} <= grant_d;
        end
    end
    always_comb begin
        QueryHit = RegWE && RegWAddr == QueryAddr;
        for (int i = 0; i < DEPTH; i++)
            if (ent_valid[i] && ent_addr[i] == QueryAddr) QueryHit = 1'b1;
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: queue-based reference model, per-cycle compare, directed pins and random traffic.
module tb_wb_port_arbiter;
    localparam int DEPTH = 4, MAX_WAIT = 8, AW = 6, DW = 32;
    logic          clk = 0, reset = 0;
    logic          PipeWE = 0, LongValid = 0;
    logic [AW-1:0] PipeWAddr = '0, LongWAddr = '0, QueryAddr = '0;
    logic [DW-1:0] PipeWData = '0, LongWData = '0;
    logic          PipeStall, LongReady, RegWE, QueryHit;
    logic [AW-1:0] RegWAddr;
    logic [DW-1:0] RegWData;

    wb_port_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT), .AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset), .PipeWE(PipeWE), .PipeWAddr(PipeWAddr), .PipeWData(PipeWData),
        .PipeStall(PipeStall), .LongValid(LongValid), .LongWAddr(LongWAddr), .LongWData(LongWData),
        .LongReady(LongReady), .RegWE(RegWE), .RegWAddr(RegWAddr), .RegWData(RegWData),
        .QueryAddr(QueryAddr), .QueryHit(QueryHit)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;
    bit run = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a queue of pending results plus a count of consecutive denials.
    typedef struct packed {logic [AW-1:0] a; logic [DW-1:0] d;} ent_t;
    ent_t          q[$];
    int            waitc = 0, mn;
    bit            forcing = 0, mpop, mpush, mdeny, e_hit;
    logic          m_we = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q.delete();
            waitc = 0; forcing = 0; m_we = 0; m_addr = '0; m_data = '0;
        end else begin
            mn    = q.size();
            mpop  = mn > 0 && (forcing || !PipeWE);
            mpush = LongValid && mn < DEPTH;
            mdeny = mn > 0 && !mpop;
            if (mpop) begin
                m_we = 1; m_addr = q[0].a; m_data = q[0].d;
            end else if (PipeWE) begin
                m_we = 1; m_addr = PipeWAddr; m_data = PipeWData;
            end else m_we = 0;
            if (mpop) void'(q.pop_front());
            if (mpush) q.push_back('{a: LongWAddr, d: LongWData});
            if (mdeny) begin
                waitc++;
                forcing = waitc == MAX_WAIT;
                if (forcing) waitc = 0;
            end else begin
                waitc = 0; forcing = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (run) begin
            e_hit = m_we && m_addr == QueryAddr;
            foreach (q[i]) if (q[i].a == QueryAddr) e_hit = 1;
            chk("RegWE", RegWE, m_we);
            chk("RegWAddr", RegWAddr, m_addr);
            chk("RegWData", RegWData, m_data);
            chk("PipeStall", PipeStall, forcing);
            chk("LongReady", LongReady, reset && q.size() < DEPTH);
            chk("QueryHit", QueryHit, e_hit);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic stream(input int base, input int n, input int pipe_until);
        int acc = 0, got = 0;
        bit a;
        PipeWAddr = 1; PipeWData = '1;
        LongValid = 1; LongWAddr = AW'(base); LongWData = DW'(base * 16);
        PipeWE = pipe_until > 0;
        for (int c = 0; c < 150 && got < n; c++) begin
            #1 a = LongValid && LongReady;
            cyc();
            if (RegWE && RegWAddr >= AW'(base)) begin
                chk("stream order", RegWAddr, base + got);
                chk("stream data", RegWData, base * 16 + got);
                got++;
            end
            if (a) begin
                acc++;
                if (acc == DEPTH && pipe_until > DEPTH) chk("full LongReady", LongReady, 0);
                if (acc < n) begin
                    LongWAddr = AW'(base + acc); LongWData = DW'(base * 16 + acc);
                end else LongValid = 0;
            end
            PipeWE = acc < pipe_until;
        end
        chk("stream drained", got, n);
        PipeWE = 0; LongValid = 0;
        cyc(); cyc();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        cyc(); cyc();
        reset = 1; run = 1;
        cyc();
        chk("reset RegWE", RegWE, 0);
        chk("reset LongReady", LongReady, 1);
        // single long result, idle pipe: write lands two cycles after accept
        LongValid = 1; LongWAddr = 40; LongWData = 32'h3F800000;
        cyc();
        LongValid = 0;
        chk("lat t+1 RegWE", RegWE, 0);
        cyc();
        chk("lat RegWE", RegWE, 1);
        chk("lat RegWAddr", RegWAddr, 40);
        chk("lat RegWData", RegWData, 32'h3F800000);
        cyc();
        // starvation: busy pipe, one queued result
        PipeWE = 1; PipeWAddr = 5; PipeWData = 32'hAAAA;
        LongValid = 1; LongWAddr = 7; LongWData = 32'h1234;
        cyc();
        LongValid = 0;
        for (int k = 1; k <= 11; k++) begin
            chk("starve PipeStall", PipeStall, k == 9);
            if (k == 10) begin
                chk("starve long addr", RegWAddr, 7);
                chk("starve long data", RegWData, 32'h1234);
            end
            if (k == 11) chk("starve held pipe", RegWAddr, 5);
            cyc();
        end
        PipeWE = 0;
        cyc(); cyc();
        stream(20, DEPTH + 1, 99);
        stream(32, 6, 0);
        stream(48, 6, DEPTH);
        // query hit through queue and output register
        QueryAddr = 12; PipeWE = 1; PipeWAddr = 1;
        LongValid = 1; LongWAddr = 12; LongWData = 5;
        cyc();
        LongValid = 0; PipeWE = 0;
        #1 chk("query queued", QueryHit, 1);
        cyc();
        #1 chk("query outreg", QueryHit, 1);
        chk("query outreg addr", RegWAddr, 12);
        cyc();
        #1 chk("query gone", QueryHit, 0);
        // reset with two entries queued
        PipeWE = 1; PipeWAddr = 1; LongValid = 1; LongWAddr = 30; LongWData = 1;
        cyc();
        LongWAddr = 31;
        cyc();
        LongValid = 0; PipeWE = 0; QueryAddr = 30;
        reset = 0;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("rst RegWE", RegWE, 0);
            chk("rst RegWAddr", RegWAddr, 0);
            chk("rst RegWData", RegWData, 0);
            chk("rst PipeStall", PipeStall, 0);
            chk("rst LongReady", LongReady, 0);
            chk("rst QueryHit", QueryHit, 0);
            cyc();
        end
        reset = 1;
        #1 chk("post-rst LongReady", LongReady, 1);
        chk("post-rst hit r30", QueryHit, 0);
        QueryAddr = 31;
        #1 chk("post-rst hit r31", QueryHit, 0);
        cyc();
        for (int c = 0; c < 3000; c++) begin
            if (!PipeStall) begin
                PipeWE = $urandom_range(0, 99) < 60;
                PipeWAddr = AW'($urandom_range(0, 15));
                PipeWData = $urandom;
            end
            LongValid = $urandom_range(0, 1) == 1;
            LongWAddr = AW'($urandom_range(0, 15));
            LongWData = $urandom;
            QueryAddr = AW'($urandom_range(0, 15));
            if (c == 1500) reset = 0;
            if (c == 1502) reset = 1;
            cyc();
        end
        PipeWE = 0; LongValid = 0;
        cyc(); cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
